// File: rtl/lsu_dtag_perr_pkg.sv
// Shared definitions for the L1D tag parity-error controller.
// LSU_DTAG_PERR_CNT_EN (in the log sub-module) enables the saturating error counter.
package lsu_dtag_perr_pkg;

  localparam int unsigned WAYS_DEF  = 4;
  localparam int unsigned IDX_W_DEF = 7;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INV  = 1'b1
  } perr_state_e;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/lsu_dtag_perr_ctl_log.sv
// Sticky tag-parity error log plus optional error counter.
// Counter is built only with LSU_DTAG_PERR_CNT_EN; otherwise perr_cnt is tied to zero.
module lsu_dtag_perr_log
  import lsu_dtag_perr_pkg::*;
#(
  parameter int unsigned WAYS  = WAYS_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det,
  input  logic [IDX_W-1:0] det_idx,
  input  logic [WAYS-1:0]  det_way,
  input  logic             log_clr,
  output logic             log_vld,
  output logic [IDX_W-1:0] log_idx,
  output logic [WAYS-1:0]  log_way,
  output logic             log_ovf,
  output logic [CNT_W-1:0] cnt
);

  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WAYS-1:0]  way_q, way_d;

  // A clear in the same cycle as a detection behaves as if the log were empty,
  // so the new entry loads and overflow drops.
  always_comb begin
    vld_d = vld_q;
    ovf_d = ovf_q;
    idx_d = idx_q;
    way_d = way_q;
    if (det) begin
      if (log_clr || !vld_q) begin
        vld_d = 1'b1;
        ovf_d = 1'b0;
        idx_d = det_idx;
        way_d = det_way;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (log_clr) begin
      vld_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
      idx_q <= '0;
      way_q <= '0;
    end else begin
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      idx_q <= idx_d;
      way_q <= way_d;
    end
  end

  assign log_vld = vld_q;
  assign log_ovf = ovf_q;
  assign log_idx = idx_q;
  assign log_way = way_q;

`ifdef LSU_DTAG_PERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (det) begin
      cnt_d = log_clr ? CNT_W'(1) : cnt_sat_inc(cnt_q);
    end else if (log_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/lsu_dtag_perr_ctl.sv
// L1D tag parity-error controller: detects errors, issues one invalidate at a time,
// traps, and logs. LSU_DTAG_PERR_CNT_EN enables the error counter in the log.
module lsu_dtag_perr_ctl
  import lsu_dtag_perr_pkg::*;
#(
  parameter int unsigned WAYS  = WAYS_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             dtag_perr_chk_vld_g,
  input  logic [WAYS-1:0]  lsu_rd_dtag_parity_g,
  input  logic [WAYS-1:0]  dva_vld_g,
  input  logic [IDX_W-1:0] dtag_idx_g,
  input  logic             dtag_perr_en,
  output logic             perr_inv_req,
  output logic [IDX_W-1:0] perr_inv_idx,
  output logic [WAYS-1:0]  perr_inv_way,
  input  logic             perr_inv_ack,
  output logic             perr_trap_g,
  output logic             perr_busy,
  output logic             perr_log_vld,
  output logic [IDX_W-1:0] perr_log_idx,
  output logic [WAYS-1:0]  perr_log_way,
  output logic             perr_log_ovf,
  input  logic             perr_log_clr,
  output logic [CNT_W-1:0] perr_cnt
);

  perr_state_e      state_q, state_d;
  logic [IDX_W-1:0] inv_idx_q, inv_idx_d;
  logic [WAYS-1:0]  inv_way_q, inv_way_d;
  logic             trap_q, trap_d;
  logic [WAYS-1:0]  err_way;
  logic             det;

  assign err_way = lsu_rd_dtag_parity_g & dva_vld_g;
  assign det     = dtag_perr_chk_vld_g & dtag_perr_en & (|err_way);

  // Detections while INV only trap and log; the pending target is never replaced,
  // and an exiting ack makes a same-cycle detection skip the invalidate.
  always_comb begin
    state_d   = state_q;
    inv_idx_d = inv_idx_q;
    inv_way_d = inv_way_q;
    trap_d    = det;
    unique case (state_q)
      ST_IDLE: begin
        if (det) begin
          state_d   = ST_INV;
          inv_idx_d = dtag_idx_g;
          inv_way_d = err_way;
        end
      end
      ST_INV: begin
        if (perr_inv_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      inv_idx_q <= '0;
      inv_way_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      inv_idx_q <= inv_idx_d;
      inv_way_q <= inv_way_d;
      trap_q    <= trap_d;
    end
  end

  assign perr_inv_req = (state_q == ST_INV);
  assign perr_busy    = (state_q == ST_INV);
  assign perr_inv_idx = inv_idx_q;
  assign perr_inv_way = inv_way_q;
  assign perr_trap_g  = trap_q;

  lsu_dtag_perr_log #(
    .WAYS  (WAYS),
    .IDX_W (IDX_W)
  ) u_log (
    .clk     (rclk),
    .reset   (reset),
    .det     (det),
    .det_idx (dtag_idx_g),
    .det_way (err_way),
    .log_clr (perr_log_clr),
    .log_vld (perr_log_vld),
    .log_idx (perr_log_idx),
    .log_way (perr_log_way),
    .log_ovf (perr_log_ovf),
    .cnt     (perr_cnt)
  );

endmodule

// File: tb/tb_lsu_dtag_perr_ctl.sv
// Directed scoreboard bench for lsu_dtag_perr_ctl; counter expectations follow LSU_DTAG_PERR_CNT_EN.
module tb_lsu_dtag_perr_ctl;

`ifdef LSU_DTAG_PERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       rclk = 1'b0;
  logic       reset;
  logic       chk_vld;
  logic [3:0] parity;
  logic [3:0] dva;
  logic [6:0] idx;
  logic       en;
  logic       inv_req;
  logic [6:0] inv_idx;
  logic [3:0] inv_way;
  logic       inv_ack;
  logic       trap;
  logic       busy;
  logic       log_vld;
  logic [6:0] log_idx;
  logic [3:0] log_way;
  logic       log_ovf;
  logic       log_clr;
  logic [7:0] cnt;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  typedef struct packed {
    logic       req;
    logic [6:0] idx;
    logic [3:0] way;
    logic       trap;
    logic       busy;
    logic       lvld;
    logic [6:0] lidx;
    logic [3:0] lway;
    logic       ovf;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  always #5 rclk = ~rclk;

  lsu_dtag_perr_ctl #(.WAYS(4), .IDX_W(7)) dut (
    .rclk                 (rclk),
    .reset                (reset),
    .dtag_perr_chk_vld_g  (chk_vld),
    .lsu_rd_dtag_parity_g (parity),
    .dva_vld_g            (dva),
    .dtag_idx_g           (idx),
    .dtag_perr_en         (en),
    .perr_inv_req         (inv_req),
    .perr_inv_idx         (inv_idx),
    .perr_inv_way         (inv_way),
    .perr_inv_ack         (inv_ack),
    .perr_trap_g          (trap),
    .perr_busy            (busy),
    .perr_log_vld         (log_vld),
    .perr_log_idx         (log_idx),
    .perr_log_way         (log_way),
    .perr_log_ovf         (log_ovf),
    .perr_log_clr         (log_clr),
    .perr_cnt             (cnt)
  );

  function automatic exp_t mk(input logic req, input logic [6:0] i, input logic [3:0] w,
                              input logic tr, input logic lv, input logic [6:0] li,
                              input logic [3:0] lw, input logic ov, input int unsigned n);
    exp_t e;
    e.req  = req;
    e.idx  = i;
    e.way  = w;
    e.trap = tr;
    e.busy = req;
    e.lvld = lv;
    e.lidx = li;
    e.lway = lw;
    e.ovf  = ov;
    e.cnt  = CNT_EN ? 8'(n) : 8'd0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic c, input logic e, input logic [3:0] p,
                       input logic [3:0] d, input logic [6:0] ix, input logic ack,
                       input logic clr);
    reset   = rst;
    chk_vld = c;
    en      = e;
    parity  = p;
    dva     = d;
    idx     = ix;
    inv_ack = ack;
    log_clr = clr;
  endtask

  // Push the expectation for the state after the next edge, then sample 1 time unit past it.
  task automatic step(input string tag, input exp_t e);
    exp_t x;
    sb_q.push_back(e);
    @(posedge rclk);
    #1;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      x = sb_q.pop_front();
      check({tag, ".req"},  {7'd0, inv_req}, {7'd0, x.req});
      check({tag, ".idx"},  {1'b0, inv_idx}, {1'b0, x.idx});
      check({tag, ".way"},  {4'd0, inv_way}, {4'd0, x.way});
      check({tag, ".trap"}, {7'd0, trap},    {7'd0, x.trap});
      check({tag, ".busy"}, {7'd0, busy},    {7'd0, x.busy});
      check({tag, ".lvld"}, {7'd0, log_vld}, {7'd0, x.lvld});
      check({tag, ".lidx"}, {1'b0, log_idx}, {1'b0, x.lidx});
      check({tag, ".lway"}, {4'd0, log_way}, {4'd0, x.lway});
      check({tag, ".ovf"},  {7'd0, log_ovf}, {7'd0, x.ovf});
      check({tag, ".cnt"},  cnt,             x.cnt);
    end
  endtask

  initial begin
    drive(1, 0, 0, 4'h0, 4'h0, 7'h00, 0, 0);
    #1;
    step("reset", mk(0, 7'h00, 4'h0, 0, 0, 7'h00, 4'h0, 0, 0));
    drive(0, 0, 0, 4'h0, 4'h0, 7'h00, 0, 0);
    step("idle", mk(0, 7'h00, 4'h0, 0, 0, 7'h00, 4'h0, 0, 0));

    // Parity errors on invalid ways, or with checking disabled, are not detections.
    drive(0, 1, 1, 4'b0010, 4'b0000, 7'h11, 0, 0);
    step("nodet_dva0", mk(0, 7'h00, 4'h0, 0, 0, 7'h00, 4'h0, 0, 0));
    drive(0, 1, 0, 4'b0100, 4'b1111, 7'h12, 0, 0);
    step("nodet_en0", mk(0, 7'h00, 4'h0, 0, 0, 7'h00, 4'h0, 0, 0));
    drive(0, 1, 1, 4'b0000, 4'b1111, 7'h13, 1, 0);
    step("nodet_par0_ack_idle", mk(0, 7'h00, 4'h0, 0, 0, 7'h00, 4'h0, 0, 0));

    drive(0, 1, 1, 4'b0100, 4'b1111, 7'h2A, 0, 0);
    step("det1", mk(1, 7'h2A, 4'b0100, 1, 1, 7'h2A, 4'b0100, 0, 1));

    drive(0, 0, 1, 4'b0000, 4'b0000, 7'h00, 0, 0);
    for (int i = 0; i < 5; i++)
      step($sformatf("hold%0d", i), mk(1, 7'h2A, 4'b0100, 0, 1, 7'h2A, 4'b0100, 0, 1));

    drive(0, 1, 1, 4'b0001, 4'b1111, 7'h05, 0, 0);
    step("det_in_inv", mk(1, 7'h2A, 4'b0100, 1, 1, 7'h2A, 4'b0100, 1, 2));
    drive(0, 0, 1, 4'b0000, 4'b0000, 7'h00, 0, 0);
    step("after_det_in_inv", mk(1, 7'h2A, 4'b0100, 0, 1, 7'h2A, 4'b0100, 1, 2));

    drive(0, 1, 1, 4'b1000, 4'b1000, 7'h11, 1, 0);
    step("ack_with_det", mk(0, 7'h2A, 4'b0100, 1, 1, 7'h2A, 4'b0100, 1, 3));
    drive(0, 0, 1, 4'b0000, 4'b0000, 7'h00, 0, 0);
    step("no_new_inv", mk(0, 7'h2A, 4'b0100, 0, 1, 7'h2A, 4'b0100, 1, 3));
    drive(0, 0, 1, 4'b0000, 4'b0000, 7'h00, 1, 0);
    step("ack_in_idle", mk(0, 7'h2A, 4'b0100, 0, 1, 7'h2A, 4'b0100, 1, 3));

    drive(0, 1, 1, 4'b0010, 4'b0011, 7'h33, 0, 1);
    step("clr_with_det", mk(1, 7'h33, 4'b0010, 1, 1, 7'h33, 4'b0010, 0, 1));
    drive(0, 0, 1, 4'b0000, 4'b0000, 7'h00, 1, 0);
    step("ack2", mk(0, 7'h33, 4'b0010, 0, 1, 7'h33, 4'b0010, 0, 1));
    drive(0, 0, 1, 4'b0000, 4'b0000, 7'h00, 0, 1);
    step("clr_only", mk(0, 7'h33, 4'b0010, 0, 0, 7'h33, 4'b0010, 0, 0));

    drive(0, 1, 1, 4'b0100, 4'b0100, 7'h40, 0, 0);
    repeat (254) @(posedge rclk);
    #1;
    step("det255", mk(1, 7'h40, 4'b0100, 1, 1, 7'h40, 4'b0100, 1, 255));
    repeat (44) @(posedge rclk);
    #1;
    step("det300", mk(1, 7'h40, 4'b0100, 1, 1, 7'h40, 4'b0100, 1, 255));

    drive(1, 0, 1, 4'b0000, 4'b0000, 7'h00, 0, 0);
    step("reset_in_inv", mk(0, 7'h00, 4'h0, 0, 0, 7'h00, 4'h0, 0, 0));
    drive(0, 0, 1, 4'b0000, 4'b0000, 7'h00, 0, 0);
    step("post_reset", mk(0, 7'h00, 4'h0, 0, 0, 7'h00, 4'h0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lsu_dtag_perr_ctl.md
LSU_DTAG_PERR_CTL -- requirements
Module: lsu_dtag_perr_ctl

Interface
REQ-001 SHALL have parameter WAYS, default 4: number of L1D ways checked.
REQ-002 SHALL have parameter IDX_W, default 7: L1D set-index width.
REQ-003 SHALL have port rclk, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port dtag_perr_chk_vld_g, input, 1: a G-stage tag read whose parity is to be checked.
REQ-006 SHALL have port lsu_rd_dtag_parity_g, input, WAYS: per-way tag parity result from the tag datapath (1 = error).
REQ-007 SHALL have port dva_vld_g, input, WAYS: G-stage flopped valid bits.
REQ-008 SHALL have port dtag_idx_g, input, IDX_W: set index of the checked access.
REQ-009 SHALL have port dtag_perr_en, input, 1: error-enable control (ASI).
REQ-010 SHALL have port perr_inv_req, output, 1: invalidate request to the valid array.
REQ-011 SHALL have port perr_inv_idx, output, IDX_W: index of the invalidate request.
REQ-012 SHALL have port perr_inv_way, output, WAYS: way mask of the invalidate request.
REQ-013 SHALL have port perr_inv_ack, input, 1: the valid array has accepted the invalidate.
REQ-014 SHALL have port perr_trap_g, output, 1: one-cycle trap pulse.
REQ-015 SHALL have port perr_busy, output, 1: fill/store stall while an invalidate is pending.
REQ-016 SHALL have ports perr_log_vld (output, 1), perr_log_idx (output, IDX_W), perr_log_way (output, WAYS) and perr_log_ovf (output, 1): sticky error log.
REQ-017 SHALL have port perr_log_clr, input, 1: software clear of the log.
REQ-018 SHALL have port perr_cnt, output, 8: error count.

Function
REQ-019 Detection SHALL be defined as det = dtag_perr_chk_vld_g & dtag_perr_en & |(lsu_rd_dtag_parity_g & dva_vld_g); err_way = lsu_rd_dtag_parity_g & dva_vld_g.
REQ-020 The FSM SHALL have states IDLE and INV; perr_busy = (state == INV).
REQ-021 In IDLE, det SHALL capture dtag_idx_g and err_way into perr_inv_idx and perr_inv_way and move the FSM to INV at the next edge.
REQ-022 In INV, perr_inv_req SHALL be 1 and perr_inv_idx and perr_inv_way SHALL be held stable.
REQ-023 perr_inv_ack sampled high in INV SHALL return the FSM to IDLE, so perr_inv_req is 0 the following cycle.
REQ-024 perr_inv_ack while in IDLE SHALL be ignored.
REQ-025 perr_trap_g SHALL pulse for exactly 1 cycle, the cycle after any det, in any state.
REQ-026 A det while in INV SHALL NOT change the invalidate target; it SHALL trap and update the log per REQ-027.
REQ-027 Log on det: if perr_log_vld = 0, load idx/way and set perr_log_vld; else set perr_log_ovf and keep the existing idx/way.
REQ-028 perr_log_clr SHALL clear perr_log_vld and perr_log_ovf; if det occurs in the same cycle, det SHALL win (load new entry, ovf = 0).
REQ-029 Minimum latency SHALL be: det at cycle N -> perr_inv_req = 1 at N+1; ack at M -> perr_inv_req = 0 at M+1.
REQ-030 A det in the same cycle as an ack that exits INV SHALL NOT start a new invalidate.

Reset
REQ-031 reset SHALL force: state IDLE; perr_inv_req, perr_trap_g, perr_busy, perr_log_vld and perr_log_ovf = 0; idx/way registers = 0; perr_cnt = 0.
REQ-032 Reset asserted mid-INV SHALL abandon the request, with perr_inv_req = 0 the cycle after reset is sampled.

Configuration
REQ-033 Macro LSU_DTAG_PERR_CNT_EN defined: perr_cnt SHALL increment on every det, saturate at 255, and be cleared by perr_log_clr (det wins on collision, giving 1).
REQ-034 Macro LSU_DTAG_PERR_CNT_EN undefined: the counter SHALL NOT be built and perr_cnt SHALL be tied to 0; the port list is unchanged.

Structure
REQ-035 Package lsu_dtag_perr_pkg SHALL hold the FSM state encoding, the WAYS/IDX_W defaults and the counter width (8).
REQ-036 The log registers and the counter SHALL live in sub-module lsu_dtag_perr_log; the FSM stays in the top.

Verification
REQ-038 Bench scenario: chk_vld = 1, en = 1, parity = 4'b0100, dva = 4'b1111, idx = 7'h2A -> next cycle req = 1, way = 4'b0100, idx = 7'h2A, trap = 1, log_vld = 1.
REQ-039 Bench scenario: hold ack = 0 for 5 cycles -> req, idx and way stable and busy = 1; ack = 1 -> req = 0 and busy = 0 next cycle.
REQ-040 Bench scenario: parity = 4'b0010, dva = 4'b0000 (or en = 0) -> no req, no trap, log unchanged.
REQ-041 Bench scenario: second det (idx 7'h05) while in INV -> trap pulses, target stays 7'h2A, log_ovf = 1.
REQ-042 Bench scenario: log_clr and det in the same cycle -> log_vld = 1 with the new idx, ovf = 0; with LSU_DTAG_PERR_CNT_EN, cnt = 1.
REQ-043 Bench scenario: 300 dets with LSU_DTAG_PERR_CNT_EN -> cnt = 255; reset asserted in INV -> req = 0 and cnt = 0 next cycle.
